// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32 pipeline: load-use bubbles, EX redirects and
// a req/ack data-memory FSM with timeout, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_memtoreg_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_redirect_i,
    input  logic             mem_access_i,
    input  logic             dmem_ack_i,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_flush_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic             dmem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int                TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]     TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e             state_q;
    logic [TW-1:0]      timer_q;
    logic               req_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               mstall_s;
    logic               lu_s;
    logic               pc_we_s;
    logic               pc_sel_s;
    logic               ifid_we_s;
    logic               ifid_flush_s;
    logic               idex_we_s;
    logic               idex_flush_s;
    logic               exmem_we_s;
    logic               memwb_we_s;

    // Memory-access FSM; ack is only honoured while a request is outstanding.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            timer_q <= {TW{1'b0}};
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_access_i) begin
                        state_q <= ST_BUSY;
                        req_q   <= 1'b1;
                        timer_q <= {TW{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack_i) begin
                        state_q <= ST_DONE;
                        req_q   <= 1'b0;
                    end else if (timer_q == TMR_LAST) begin
                        state_q <= ST_ERR;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Hazard detection terms.
    always_comb begin
        mstall_s = (mem_access_i && (state_q != ST_DONE)) || (state_q == ST_ERR);
        lu_s     = ex_memtoreg_i && (ex_rd_i != 5'd0) &&
                   ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                    (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
    end

    // Pipeline enables by priority: reset, memory stall, redirect, load-use, normal.
    always_comb begin
        pc_we_s      = 1'b1;
        pc_sel_s     = 1'b0;
        ifid_we_s    = 1'b1;
        ifid_flush_s = 1'b0;
        idex_we_s    = 1'b1;
        idex_flush_s = 1'b0;
        exmem_we_s   = 1'b1;
        memwb_we_s   = 1'b1;
        if (!rst_n_i) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            ifid_flush_s = 1'b1;
            idex_we_s    = 1'b0;
            idex_flush_s = 1'b1;
            exmem_we_s   = 1'b0;
            memwb_we_s   = 1'b0;
        end else if (mstall_s) begin
            pc_we_s    = 1'b0;
            ifid_we_s  = 1'b0;
            idex_we_s  = 1'b0;
            exmem_we_s = 1'b0;
            memwb_we_s = 1'b0;
        end else if (ex_redirect_i) begin
            pc_sel_s     = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (lu_s) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_flush_s = 1'b1;
        end else begin
            pc_sel_s = 1'b0;
        end
    end

    // Next stall count, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (!pc_we_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pc_we_o      = pc_we_s;
    assign pc_sel_o     = pc_sel_s;
    assign ifid_we_o    = ifid_we_s;
    assign ifid_flush_o = ifid_flush_s;
    assign idex_we_o    = idex_we_s;
    assign idex_flush_o = idex_flush_s;
    assign exmem_we_o   = exmem_we_s;
    assign memwb_we_o   = memwb_we_s;
    assign dmem_req_o   = req_q;
    assign err_o        = err_q;
    assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (TIMEOUT=8, CNT_W=4): per-cycle expected
// enables, req/err and stall count are queued with each stimulus row.
module tb_pipe_hazard_ctrl;

    localparam int         TIMEOUT = 8;
    localparam int         CNT_W   = 4;
    localparam logic [3:0] CMAX    = 4'd15;
    localparam int M_N = 0, M_R = 1, M_L = 2, M_S = 3, M_X = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mtr, redir, macc, ack;
    logic       pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we;
    logic       req, err;
    logic [3:0] stall_cnt;
    logic [9:0] obs;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mtr, redir, macc, ack;
        int         mode;
        logic       req, err;
    } row_t;

    typedef struct {
        logic [9:0] ctrl;
        logic [9:0] mask;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_cnt = 4'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1), .id_use_rs2_i(u2),
        .ex_memtoreg_i(mtr), .ex_rd_i(rd), .ex_redirect_i(redir),
        .mem_access_i(macc), .dmem_ack_i(ack),
        .pc_we_o(pc_we), .pc_sel_o(pc_sel), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
        .idex_we_o(idex_we), .idex_flush_o(idex_flush), .exmem_we_o(exmem_we),
        .memwb_we_o(memwb_we), .dmem_req_o(req), .err_o(err), .stall_cnt_o(stall_cnt)
    );

    assign obs = {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush,
                  exmem_we, memwb_we, req, err};

    function automatic row_t mk(logic [4:0] a1, logic b1, logic [4:0] a2, logic b2,
                                logic m, logic [4:0] d, logic r, logic ma, logic ak,
                                int mode, logic q, logic e);
        row_t x;
        x.rs1 = a1; x.u1 = b1; x.rs2 = a2; x.u2 = b2; x.mtr = m; x.rd = d;
        x.redir = r; x.macc = ma; x.ack = ak; x.mode = mode; x.req = q; x.err = e;
        return x;
    endfunction

    // {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}
    function automatic logic [7:0] mode_bits(int m);
        case (m)
            M_N:     return 8'b1010_1011;
            M_R:     return 8'b1111_1111;
            M_L:     return 8'b0000_1111;
            M_S:     return 8'b0000_0000;
            default: return 8'b0001_0100;
        endcase
    endfunction

    // Write enables shadowed by their flush are left unchecked.
    function automatic logic [9:0] mode_mask(int m);
        case (m)
            M_R:     return 10'b11_0101_1111;
            M_L:     return 10'b11_1101_1111;
            default: return 10'b11_1111_1111;
        endcase
    endfunction

    task automatic drive_row(input row_t r);
        exp_t e;
        rs1 = r.rs1; u1 = r.u1; rs2 = r.rs2; u2 = r.u2; mtr = r.mtr; rd = r.rd;
        redir = r.redir; macc = r.macc; ack = r.ack;
        e.ctrl = {mode_bits(r.mode), r.req, r.err};
        e.mask = mode_mask(r.mode);
        e.cnt  = exp_cnt;
        sbq.push_back(e);
        if (r.mode == M_S || r.mode == M_L) begin
            exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 4'd1;
        end
    endtask

    task automatic do_reset();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0; mtr = 1'b0;
        redir = 1'b0; macc = 1'b0; ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        sbq.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        exp_cnt = 4'd0;
        drive_row(mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, M_X, 1'b0, 1'b0));
        @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
            failures++;
            $display("FAIL reset: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                     obs, stall_cnt, e.ctrl, e.cnt);
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_L, 1'b0, 1'b0));
        rows.push_back(mk(5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        rows.push_back(mk(5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, M_L, 1'b0, 1'b0));
        rows.push_back(mk(5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL load_use row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_stall();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        rows.push_back(mk(5'd3, 1'b1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        rows.push_back(mk(5'd5, 1'b0, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        rows.push_back(mk(5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL no_stall row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(5'd5, 1'b1, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, M_R, 1'b0, 1'b0));
        rows.push_back(mk(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, M_R, 1'b0, 1'b0));
        rows.push_back(mk(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL redirect row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_access();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b0, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b1, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b1, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, M_S, 1'b1, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_N, 1'b0, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, M_N, 1'b0, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL mem_access row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b0, 1'b0));
            rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, M_S, 1'b1, 1'b0));
            rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_N, 1'b0, 1'b0));
        end
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL back_to_back row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_in_mstall();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, M_S, 1'b0, 1'b0));
        rows.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, M_S, 1'b1, 1'b0));
        rows.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, M_R, 1'b0, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL redirect_in_mstall row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        row_t rows[$];
        exp_t e;
        for (int k = 0; k < 20; k++) begin
            rows.push_back(mk(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, M_L, 1'b0, 1'b0));
        end
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_N, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL saturation row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b0, 1'b0));
        for (int k = 0; k < TIMEOUT; k++) begin
            rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b1, 1'b0));
        end
        for (int k = 0; k < 3; k++) begin
            rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, M_S, 1'b0, 1'b1));
        end
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL timeout row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
        // Mid-cycle asynchronous reset out of ERR.
        #2;
        rst_n = 1'b0;
        exp_cnt = 4'd0;
        drive_row(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, M_X, 1'b0, 1'b0));
        #1;
        e = sbq.pop_front();
        checks++;
        if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
            failures++;
            $display("FAIL timeout_async_reset: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                     obs, stall_cnt, e.ctrl, e.cnt);
        end
    endtask

    task automatic test_abort();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b0, 1'b0));
        rows.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_S, 1'b1, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
                failures++;
                $display("FAIL abort row %0d: got ctrl=%b cnt=%0d, expected ctrl=%b mask=%b cnt=%0d",
                         i, obs, stall_cnt, e.ctrl, e.mask, e.cnt);
            end
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        exp_cnt = 4'd0;
        drive_row(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, M_X, 1'b0, 1'b0));
        #1;
        e = sbq.pop_front();
        checks++;
        if ((((obs ^ e.ctrl) & e.mask) !== 10'd0) || (stall_cnt !== e.cnt)) begin
            failures++;
            $display("FAIL abort_async_reset: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                     obs, stall_cnt, e.ctrl, e.cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0; mtr = 1'b0;
        redir = 1'b0; macc = 1'b0; ack = 1'b0;
        test_reset();
        do_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        do_reset();
        test_mem_access();
        do_reset();
        test_back_to_back();
        do_reset();
        test_redirect_in_mstall();
        do_reset();
        test_saturation();
        do_reset();
        test_timeout();
        do_reset();
        test_abort();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
